// File: rtl/dpram_fifo.sv
// dpram_fifo: first-word-fall-through FIFO around a bypassing dual-port RAM.
// The RAM read port is registered; bypass makes a same-edge write visible on RData.
module dpram #(
    parameter int MEMD   = 16,
    parameter int DATAW  = 32,
    parameter int BYPASS = 1,
    parameter int IZERO  = 0,
    localparam int AW    = $clog2(MEMD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WEnb,
    input  logic [AW-1:0]    WAddr,
    input  logic [DATAW-1:0] WData,
    input  logic [AW-1:0]    RAddr,
    output logic [DATAW-1:0] RData
);
    logic [DATAW-1:0] mem_q [MEMD];
    logic [DATAW-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = (BYPASS != 0 && WEnb && WAddr == RAddr) ? WData : mem_q[RAddr];
    end

    always_ff @(posedge clk) begin
        if (WEnb) mem_q[WAddr] <= WData;
    end

    // Storage is never cleared; IZERO only zeroes the read register.
    always_ff @(posedge clk) begin
        if (rst && IZERO != 0) rdata_q <= '0;
        else                   rdata_q <= rdata_d;
    end

    assign RData = rdata_q;
endmodule

module dpram_fifo #(
    parameter int MEMD  = 16,
    parameter int DATAW = 32,
    parameter int AFULL = 12,
    parameter int IZERO = 0,
    localparam int AW   = $clog2(MEMD),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             almost_full
);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          almost_full_q, almost_full_d;
    logic          push, pop;

    assign in_ready    = (count_q != CW'(MEMD)) & ~rst;
    assign out_valid   = count_q != '0;
    assign count       = count_q;
    assign almost_full = almost_full_q;

    always_comb begin
        push          = in_valid & in_ready;
        pop           = out_valid & out_ready;
        wr_ptr_d      = wr_ptr_q + AW'(push);
        rd_ptr_d      = rd_ptr_q + AW'(pop);
        count_d       = (push & ~pop) ? count_q + CW'(1) :
                        (pop & ~push) ? count_q - CW'(1) : count_q;
        almost_full_d = count_d >= CW'(AFULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Reading at the next read pointer keeps the head on RData with zero pop latency.
    dpram #(
        .MEMD(MEMD), .DATAW(DATAW), .BYPASS(1), .IZERO(IZERO)
    ) u_ram (
        .clk(clk), .rst(rst),
        .WEnb(push), .WAddr(wr_ptr_q), .WData(in_data),
        .RAddr(rd_ptr_d), .RData(out_data)
    );
endmodule

// File: tb/tb_dpram_fifo.sv
// tb_dpram_fifo: table-driven vectors plus hand-written fill/drain and streaming sequences.
module tb_dpram_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, almost_full;
    logic [31:0] out_data;
    logic [4:0]  count;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    dpram_fifo #(.MEMD(16), .DATAW(32), .AFULL(12), .IZERO(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full)
    );

    typedef struct {
        logic        r, iv, ordy;
        logic [31:0] din;
        int          cnt;
        logic        ov, ir, af, chk_d;
        logic [31:0] dout;
    } vec_t;
    vec_t vq[$];

    function automatic void add(logic r, logic iv, logic o, logic [31:0] d, int c,
                                logic ov, logic ir, logic af, logic cd, logic [31:0] dout);
        vq.push_back('{r, iv, o, d, c, ov, ir, af, cd, dout});
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 32'hA0 + i, i + 1, 1, 1, 0, 1, 32'hA0);
        add(0, 0, 1, 0, 3, 1, 1, 0, 1, 32'hA1);
        add(0, 0, 1, 0, 2, 1, 1, 0, 1, 32'hA2);
        add(0, 0, 1, 0, 1, 1, 1, 0, 1, 32'hA3);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 32'h1234, 1, 1, 1, 0, 1, 32'h1234);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 1, 0, 32'hB0 + i, i + 1, 1, 1, 0, 1, 32'hB0);
        add(1, 1, 0, 32'hEE, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 32'h55, 1, 1, 1, 0, 1, 32'h55);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);

        #2;
        foreach (vq[i]) begin
            rst = vq[i].r; in_valid = vq[i].iv; out_ready = vq[i].ordy; in_data = vq[i].din;
            step();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vq[i].cnt));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].ov));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vq[i].ir));
            chk($sformatf("v%0d_almost_full", i), 32'(almost_full), 32'(vq[i].af));
            if (vq[i].chk_d) chk($sformatf("v%0d_out_data", i), out_data, vq[i].dout);
        end

        // Fill to full, reject extra pushes, then pop from full and drain in order.
        rst = 1; in_valid = 0; out_ready = 0;
        step();
        rst = 0;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1; in_data = 32'(k);
            step();
            chk($sformatf("fill%0d_count", k), 32'(count), 32'(k + 1));
            chk($sformatf("fill%0d_af", k), 32'(almost_full), 32'(k + 1 >= 12));
            chk($sformatf("fill%0d_in_ready", k), 32'(in_ready), 32'(k + 1 < 16));
            chk($sformatf("fill%0d_head", k), out_data, 32'h0);
        end
        in_data = 32'h99;
        step();
        chk("overfill_count", 32'(count), 32'd16);
        chk("overfill_in_ready", 32'(in_ready), 32'd0);
        chk("overfill_head", out_data, 32'h0);
        in_data = 32'h77; out_ready = 1;
        step();
        chk("fullpop_count", 32'(count), 32'd15);
        chk("fullpop_in_ready", 32'(in_ready), 32'd1);
        chk("fullpop_af", 32'(almost_full), 32'd1);
        chk("fullpop_head", out_data, 32'h1);
        in_valid = 0;
        for (int j = 1; j < 16; j++) begin
            chk($sformatf("drain%0d_valid", j), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_data", j), out_data, 32'(j));
            step();
        end
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_af", 32'(almost_full), 32'd0);

        // Sustained push+pop at count=1 across several pointer wraps.
        rst = 1; out_ready = 0;
        step();
        rst = 0; in_valid = 1; in_data = 32'h300;
        step();
        chk("stream_start_count", 32'(count), 32'd1);
        out_ready = 1;
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("stream%0d_data", i), out_data, 32'h300 + 32'(i));
            in_data = 32'h301 + 32'(i);
            step();
            chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
        end
        chk("stream_last_data", out_data, 32'h300 + 32'd40);
        in_valid = 0;
        step();
        chk("stream_end_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
